// File: rtl/idex_hazard_ctrl.sv
// ID/EX hazard and sequencing controller: RAW stall detection, taken-branch squash, saturating stats.
// Optional build macro HAZARD_FWD_EN: a forwarding unit exists, so only load-use hazards stall.
module idex_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             EX_RegWrite,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_DestReg,
   input  logic             MEM_RegWrite,
   input  logic [4:0]       MEM_DestReg,
   input  logic             EX_BranchTaken,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Bubble,
   output logic             Stalled,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushCount
);

   typedef enum logic {RUN, STALL} state_t;

   state_t state;
   logic   match_ex;
   logic   hazard;
   logic   need_two;
   logic   stall;
   logic   flush;

   // Register 0 is hardwired, so it can never be a real producer.
   assign match_ex = EX_RegWrite && (EX_DestReg != 5'd0) &&
                     ((ID_UsesRs && (ID_Rs == EX_DestReg)) ||
                      (ID_UsesRt && (ID_Rt == EX_DestReg)));

`ifdef HAZARD_FWD_EN
   logic unused_mem_inputs;
   assign unused_mem_inputs = &{1'b0, MEM_RegWrite, MEM_DestReg};
   assign hazard   = match_ex && EX_MemRead;
   assign need_two = 1'b0;
`else
   logic match_mem;
   logic unused_memread;
   assign unused_memread = &{1'b0, EX_MemRead};
   assign match_mem = MEM_RegWrite && (MEM_DestReg != 5'd0) &&
                      ((ID_UsesRs && (ID_Rs == MEM_DestReg)) ||
                       (ID_UsesRt && (ID_Rt == MEM_DestReg)));
   // Split-cycle regfile: an EX producer needs two bubbles, a MEM producer one.
   assign hazard   = match_ex || match_mem;
   assign need_two = match_ex;
`endif

   assign flush   = EX_BranchTaken;
   assign stall   = (state == STALL) || hazard;
   assign Stalled = (state == STALL);

   always_comb begin
      PCWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      if (Reset) begin
         PCWrite     = 1'b0;
         IFID_Write  = 1'b0;
         IFID_Flush  = 1'b1;
         IDEX_Bubble = 1'b1;
      end else if (flush) begin
         IFID_Flush  = 1'b1;
         IDEX_Bubble = 1'b1;
      end else if (stall) begin
         PCWrite     = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b1;
      end
   end

   // A taken branch wins over any owed stall cycle and returns to RUN.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= RUN;
         StallCycles <= '0;
         FlushCount  <= '0;
      end else begin
         if (flush)
            state <= RUN;
         else if ((state == RUN) && hazard && need_two)
            state <= STALL;
         else
            state <= RUN;
         if (stall && !flush && (StallCycles != '1))
            StallCycles <= StallCycles + CNT_W'(1);
         if (flush && (FlushCount != '1))
            FlushCount <= FlushCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Directed bench for idex_hazard_ctrl; follows the build's HAZARD_FWD_EN setting.
module tb_idex_hazard_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [4:0]  ID_Rs, ID_Rt, EX_DestReg, MEM_DestReg;
   logic        ID_UsesRs, ID_UsesRt, EX_RegWrite, EX_MemRead, MEM_RegWrite, EX_BranchTaken;
   logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Stalled;
   logic [15:0] StallCycles, FlushCount;
   logic [4:0]  ctl;

   int tests_run = 0;
   int tests_failed = 0;
   logic [15:0] exp_stall = 16'd0;
   logic [15:0] exp_flush = 16'd0;

   // ctl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Stalled}
   localparam logic [4:0] C_RUN    = 5'b11000;
   localparam logic [4:0] C_STALL1 = 5'b00010;
   localparam logic [4:0] C_STALL2 = 5'b00011;
   localparam logic [4:0] C_FLUSHR = 5'b11110;
   localparam logic [4:0] C_FLUSHS = 5'b11111;
   localparam logic [4:0] C_RESET  = 5'b00110;

   assign ctl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Stalled};

   idex_hazard_ctrl #(.CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
      .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_DestReg(EX_DestReg),
      .MEM_RegWrite(MEM_RegWrite), .MEM_DestReg(MEM_DestReg),
      .EX_BranchTaken(EX_BranchTaken),
      .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
      .IDEX_Bubble(IDEX_Bubble), .Stalled(Stalled),
      .StallCycles(StallCycles), .FlushCount(FlushCount)
   );

   always #5 Clk = ~Clk;

   task automatic clear_inputs();
      ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
      EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_DestReg = 5'd0;
      MEM_RegWrite = 1'b0; MEM_DestReg = 5'd0; EX_BranchTaken = 1'b0;
   endtask

   // Inputs change just after the falling edge; checks follow 1 time unit later.
   task automatic next_cycle();
      @(negedge Clk);
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk); #1;
         tests_run++;
         if (ctl !== C_RESET) begin
            tests_failed++;
            $display("FAIL reset_ctl[%0d] got %b want %b", i, ctl, C_RESET);
         end
      end
      @(negedge Clk); Reset = 1'b0; #1;
      tests_run++;
      if (ctl !== C_RUN) begin
         tests_failed++; $display("FAIL release_ctl got %b want %b", ctl, C_RUN);
      end
      tests_run++;
      if (StallCycles !== 16'd0 || FlushCount !== 16'd0) begin
         tests_failed++;
         $display("FAIL release_cnt got %h/%h want 0000/0000", StallCycles, FlushCount);
      end
   endtask

   task automatic test_reg_zero();
      next_cycle();
      EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_DestReg = 5'd0;
      MEM_RegWrite = 1'b1; MEM_DestReg = 5'd0;
      ID_Rs = 5'd0; ID_UsesRs = 1'b1; ID_Rt = 5'd0; ID_UsesRt = 1'b1; #1;
      tests_run++;
      if (ctl !== C_RUN) begin
         tests_failed++; $display("FAIL reg_zero_ctl got %b want %b", ctl, C_RUN);
      end
      next_cycle(); #1;
      tests_run++;
      if (StallCycles !== exp_stall) begin
         tests_failed++; $display("FAIL reg_zero_cnt got %h want %h", StallCycles, exp_stall);
      end
   endtask

`ifdef HAZARD_FWD_EN
   task automatic test_load_use();
      next_cycle();
      EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_DestReg = 5'd8;
      ID_Rs = 5'd8; ID_UsesRs = 1'b1; #1;
      tests_run++;
      if (ctl !== C_STALL1) begin
         tests_failed++; $display("FAIL load_use_ctl got %b want %b", ctl, C_STALL1);
      end
      exp_stall = exp_stall + 16'd1;
      next_cycle(); #1;
      tests_run++;
      if (ctl !== C_RUN) begin
         tests_failed++; $display("FAIL load_use_after got %b want %b", ctl, C_RUN);
      end
      tests_run++;
      if (StallCycles !== exp_stall) begin
         tests_failed++; $display("FAIL load_use_cnt got %h want %h", StallCycles, exp_stall);
      end
   endtask

   task automatic test_no_stall_forwarded();
      // Non-load EX producer and a MEM producer are both covered by forwarding.
      next_cycle();
      EX_RegWrite = 1'b1; EX_DestReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1; #1;
      tests_run++;
      if (ctl !== C_RUN) begin
         tests_failed++; $display("FAIL ex_alu_ctl got %b want %b", ctl, C_RUN);
      end
      next_cycle();
      MEM_RegWrite = 1'b1; MEM_DestReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1; #1;
      tests_run++;
      if (ctl !== C_RUN) begin
         tests_failed++; $display("FAIL mem_fwd_ctl got %b want %b", ctl, C_RUN);
      end
      next_cycle(); #1;
      tests_run++;
      if (StallCycles !== exp_stall) begin
         tests_failed++; $display("FAIL fwd_cnt got %h want %h", StallCycles, exp_stall);
      end
   endtask

   task automatic test_branch_over_stall();
      next_cycle();
      EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_DestReg = 5'd8;
      ID_Rs = 5'd8; ID_UsesRs = 1'b1; EX_BranchTaken = 1'b1; #1;
      tests_run++;
      if (ctl !== C_FLUSHR) begin
         tests_failed++; $display("FAIL branch_ctl got %b want %b", ctl, C_FLUSHR);
      end
      exp_flush = exp_flush + 16'd1;
      next_cycle(); #1;
      tests_run++;
      if (FlushCount !== exp_flush || StallCycles !== exp_stall) begin
         tests_failed++;
         $display("FAIL branch_cnt got %h/%h want %h/%h", FlushCount, StallCycles, exp_flush, exp_stall);
      end
   endtask
`else
   task automatic test_ex_hazard();
      next_cycle();
      EX_RegWrite = 1'b1; EX_DestReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1; #1;
      tests_run++;
      if (ctl !== C_STALL1) begin
         tests_failed++; $display("FAIL ex_haz_c1 got %b want %b", ctl, C_STALL1);
      end
      next_cycle(); #1;
      tests_run++;
      if (ctl !== C_STALL2) begin
         tests_failed++; $display("FAIL ex_haz_c2 got %b want %b", ctl, C_STALL2);
      end
      exp_stall = exp_stall + 16'd2;
      next_cycle(); #1;
      tests_run++;
      if (ctl !== C_RUN) begin
         tests_failed++; $display("FAIL ex_haz_c3 got %b want %b", ctl, C_RUN);
      end
      tests_run++;
      if (StallCycles !== exp_stall) begin
         tests_failed++; $display("FAIL ex_haz_cnt got %h want %h", StallCycles, exp_stall);
      end
   endtask

   task automatic test_mem_hazard();
      next_cycle();
      MEM_RegWrite = 1'b1; MEM_DestReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1; #1;
      tests_run++;
      if (ctl !== C_STALL1) begin
         tests_failed++; $display("FAIL mem_haz_c1 got %b want %b", ctl, C_STALL1);
      end
      exp_stall = exp_stall + 16'd1;
      next_cycle(); #1;
      tests_run++;
      if (ctl !== C_RUN) begin
         tests_failed++; $display("FAIL mem_haz_c2 got %b want %b", ctl, C_RUN);
      end
      tests_run++;
      if (StallCycles !== exp_stall) begin
         tests_failed++; $display("FAIL mem_haz_cnt got %h want %h", StallCycles, exp_stall);
      end
   endtask

   task automatic test_both_match();
      // EX and MEM both produce rs: the EX match sets the length to 2.
      next_cycle();
      EX_RegWrite = 1'b1; EX_DestReg = 5'd4; MEM_RegWrite = 1'b1; MEM_DestReg = 5'd4;
      ID_Rs = 5'd4; ID_UsesRs = 1'b1; #1;
      next_cycle(); #1;
      tests_run++;
      if (ctl !== C_STALL2) begin
         tests_failed++; $display("FAIL both_match_c2 got %b want %b", ctl, C_STALL2);
      end
      exp_stall = exp_stall + 16'd2;
      next_cycle();
   endtask

   task automatic test_branch_in_stall();
      next_cycle();
      EX_RegWrite = 1'b1; EX_DestReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1; #1;
      exp_stall = exp_stall + 16'd1;
      next_cycle();
      EX_BranchTaken = 1'b1; #1;
      tests_run++;
      if (ctl !== C_FLUSHS) begin
         tests_failed++; $display("FAIL branch_stall_ctl got %b want %b", ctl, C_FLUSHS);
      end
      exp_flush = exp_flush + 16'd1;
      next_cycle(); #1;
      tests_run++;
      if (ctl !== C_RUN) begin
         tests_failed++; $display("FAIL branch_stall_next got %b want %b", ctl, C_RUN);
      end
      tests_run++;
      if (FlushCount !== exp_flush || StallCycles !== exp_stall) begin
         tests_failed++;
         $display("FAIL branch_stall_cnt got %h/%h want %h/%h", FlushCount, StallCycles, exp_flush, exp_stall);
      end
   endtask
`endif

   task automatic test_flush_saturation();
      next_cycle();
      EX_BranchTaken = 1'b1;
      repeat (65536) @(negedge Clk);
      #1;
      tests_run++;
      if (FlushCount !== 16'hFFFF) begin
         tests_failed++; $display("FAIL flush_sat got %h want ffff", FlushCount);
      end
      next_cycle(); #1;
      tests_run++;
      if (FlushCount !== 16'hFFFF) begin
         tests_failed++; $display("FAIL flush_sat_hold got %h want ffff", FlushCount);
      end
   endtask

   task automatic test_reset_mid_stall();
      next_cycle();
`ifdef HAZARD_FWD_EN
      EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_DestReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1;
      #1;
`else
      EX_RegWrite = 1'b1; EX_DestReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
      next_cycle(); #1;
      tests_run++;
      if (Stalled !== 1'b1) begin
         tests_failed++; $display("FAIL pre_reset_stalled got %b want 1", Stalled);
      end
`endif
      #1 Reset = 1'b1; #1;
      tests_run++;
      if (ctl !== C_RESET) begin
         tests_failed++; $display("FAIL mid_reset_ctl got %b want %b", ctl, C_RESET);
      end
      tests_run++;
      if (StallCycles !== 16'd0 || FlushCount !== 16'd0) begin
         tests_failed++;
         $display("FAIL mid_reset_cnt got %h/%h want 0000/0000", StallCycles, FlushCount);
      end
      next_cycle();
      Reset = 1'b0; #1;
      tests_run++;
      if (ctl !== C_RUN) begin
         tests_failed++; $display("FAIL post_reset_ctl got %b want %b", ctl, C_RUN);
      end
   endtask

   initial begin
      test_reset();
      test_reg_zero();
`ifdef HAZARD_FWD_EN
      test_load_use();
      test_no_stall_forwarded();
      test_branch_over_stall();
`else
      test_ex_hazard();
      test_mem_hazard();
      test_both_match();
      test_branch_in_stall();
`endif
      test_reg_zero();
      test_flush_saturation();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
